// File: rtl/node_pkg.sv
// Shared constants for the node ejection path: default word width, the all-zero word
// and the reset polarity used by the node clock domain.
package node_pkg;

  localparam int unsigned NODE_DATA_W = 32;

  localparam logic [NODE_DATA_W-1:0] NODE_WORD_ZERO = '0;

  // The node domain resets when shiftInRSTn is low.
  localparam logic NODE_RST_ACTIVE = 1'b0;

  // Reports whether a reset level is the asserted one.
  function automatic logic node_rst_asserted(input logic rst_level);
    return rst_level == NODE_RST_ACTIVE;
  endfunction

endpackage

// File: rtl/node_fifo_mem.sv
// DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset; occupancy tracking lives in the owner.
module node_fifo_mem
  import node_pkg::*;
#(
  parameter int unsigned DATA_W = NODE_DATA_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/node_eject_buffer.sv
// Ejection stage behind the node's local output: captures every strobed word into a FWFT FIFO,
// drains it over valid/ready, and counts words lost when the FIFO is full (the node cannot stall).
module node_eject_buffer
  import node_pkg::*;
#(
  parameter int unsigned DATA_W = NODE_DATA_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              shiftInCLK,
  input  logic              shiftInRSTn,
  input  logic [DATA_W-1:0] shiftInData,
  input  logic              shiftInCS,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  input  logic              outReady,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [CNT_W-1:0]  dropCount,
  input  logic              clearOverflow
);

  localparam logic [ADDR_W:0]   LevelFull = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LevelOne  = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0]  CntOne    = CNT_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              push, pop, wr_en, drop;
  logic [DATA_W-1:0] rd_data;

  assign full  = (level_q == LevelFull);
  assign empty = (level_q == '0);

  assign push  = shiftInCS;
  assign pop   = outValid & outReady;
  // A pop in the same cycle frees the slot the push needs, so full alone does not force a drop.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end

    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase

    // A drop coinciding with a clear restarts the count at one.
    if (drop) begin
      overflow_d = 1'b1;
      if (clearOverflow) begin
        drop_cnt_d = CntOne;
      end else if (!(&drop_cnt_q)) begin
        drop_cnt_d = drop_cnt_q + CntOne;
      end
    end else if (clearOverflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge shiftInCLK or negedge shiftInRSTn) begin
    if (node_rst_asserted(shiftInRSTn)) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  node_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i     (shiftInCLK),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (shiftInData),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  assign outValid  = ~empty;
  assign outData   = empty ? DATA_W'(NODE_WORD_ZERO) : rd_data;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign dropCount = drop_cnt_q;

endmodule
